// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with writeback bypass and a per-register busy scoreboard.
// Optional build macro ZERO_REG_EN hardwires register 0 to zero and never marks it busy.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 2,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_dst,
    output logic                       stall,
    input  logic                       wr,
    input  logic [ADDR_W-1:0]          wr_dst,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       flush,
    output logic [ADDR_W:0]            busy_count
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                wr_eff;
    logic                issue_ok;
    logic                raw;
    logic                waw;
    logic                do_set;
    logic                do_clr;
    logic                inc;
    logic                dec;
    logic [ADDR_W-1:0]   addr;

`ifdef ZERO_REG_EN
    // Dropping writes to r0 also kills its bypass, so r0 always reads as its reset value.
    assign wr_eff   = wr && (wr_dst != '0);
    assign issue_ok = (issue_dst != '0);
`else
    assign wr_eff   = wr;
    assign issue_ok = 1'b1;
`endif

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        raw     = 1'b0;
        addr    = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            addr = rd_addr[i*ADDR_W +: ADDR_W];
            if (wr_eff && (wr_dst == addr)) begin
                rd_data[i*DATA_W +: DATA_W] = wr_data;
                rd_busy[i]                  = 1'b0;
            end else begin
                rd_data[i*DATA_W +: DATA_W] = regs[addr];
                rd_busy[i]                  = busy[addr];
            end
            raw = raw | (rd_en[i] & rd_busy[i]);
        end
    end

    always_comb begin
        waw    = busy[issue_dst] && !(wr_eff && (wr_dst == issue_dst));
        stall  = issue_valid && (raw || waw) && !flush;
        do_set = issue_valid && !stall && issue_ok;
        do_clr = wr_eff && busy[wr_dst];
        // A set can only meet an already-busy bit when the same-cycle writeback clears it.
        inc    = do_set && !busy[issue_dst];
        dec    = do_clr && !(do_set && (issue_dst == wr_dst));
        busy_nxt = busy;
        if (wr_eff) busy_nxt[wr_dst] = 1'b0;
        if (do_set) busy_nxt[issue_dst] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else if (wr_eff) begin
            regs[wr_dst] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else if (flush) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy <= busy_nxt;
            case ({inc, dec})
                2'b10:   busy_count <= busy_count + 1'b1;
                2'b01:   busy_count <= busy_count - 1'b1;
                default: busy_count <= busy_count;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters).
// Expectations follow ZERO_REG_EN when the bench is built with that macro.
module tb_regfile_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

`ifdef ZERO_REG_EN
    localparam logic [31:0] R0_EXP    = 32'h0;
    localparam int          R0_CNT    = 0;
    localparam int          FULL_CNT  = 15;
`else
    localparam logic [31:0] R0_EXP    = 32'hFFFF_FFFF;
    localparam int          R0_CNT    = 1;
    localparam int          FULL_CNT  = 16;
`endif

    logic                  clk;
    logic                  rst_n;
    logic [1:0]            rd_en;
    logic [2*ADDR_W-1:0]   rd_addr;
    logic [2*DATA_W-1:0]   rd_data;
    logic [1:0]            rd_busy;
    logic                  issue_valid;
    logic [ADDR_W-1:0]     issue_dst;
    logic                  stall;
    logic                  wr;
    logic [ADDR_W-1:0]     wr_dst;
    logic [DATA_W-1:0]     wr_data;
    logic                  flush;
    logic [ADDR_W:0]       busy_count;

    int errors = 0;
    int checks = 0;

    regfile_scoreboard #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(2)) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_busy(rd_busy), .issue_valid(issue_valid),
        .issue_dst(issue_dst), .stall(stall), .wr(wr), .wr_dst(wr_dst),
        .wr_data(wr_data), .flush(flush), .busy_count(busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = '0; issue_valid = 1'b0; issue_dst = '0;
        wr = 1'b0; wr_dst = '0; wr_data = '0; flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rd_addr = '0;
        idle();
        #12;
        chk("reset_count", 64'(busy_count), 64'd0);
        chk("reset_rd0", 64'(rd_data[31:0]), 64'd0);
        chk("reset_rd1", 64'(rd_data[63:32]), 64'd0);
        chk("reset_busy", 64'(rd_busy), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        #10 rst_n = 1'b1;

        // Write r3, read it back
        tick();
        wr = 1'b1; wr_dst = 4'd3; wr_data = 32'hDEADBEEF;
        tick();
        idle(); rd_addr[3:0] = 4'd3;
        #1;
        chk("readback_r3", 64'(rd_data[31:0]), 64'hDEADBEEF);
        chk("readback_busy", 64'(rd_busy), 64'd0);
        chk("readback_count", 64'(busy_count), 64'd0);

        // Same-cycle bypass on port 1
        wr = 1'b1; wr_dst = 4'd5; wr_data = 32'h12345678; rd_addr[7:4] = 4'd5;
        #1;
        chk("bypass_rd1", 64'(rd_data[63:32]), 64'h12345678);
        chk("bypass_rd0", 64'(rd_data[31:0]), 64'hDEADBEEF);

        // RAW hazard
        tick();
        idle(); issue_valid = 1'b1; issue_dst = 4'd2;
        #1;
        chk("issue2_stall", 64'(stall), 64'd0);
        tick();
        chk("issue2_count", 64'(busy_count), 64'd1);
        issue_dst = 4'd10; rd_en = 2'b01; rd_addr[3:0] = 4'd2;
        #1;
        chk("raw_stall", 64'(stall), 64'd1);
        chk("raw_busy0", 64'(rd_busy[0]), 64'd1);
        tick();
        chk("raw_count_hold", 64'(busy_count), 64'd1);
        wr = 1'b1; wr_dst = 4'd2; wr_data = 32'h55;
        #1;
        chk("raw_resolved_stall", 64'(stall), 64'd0);
        chk("raw_resolved_data", 64'(rd_data[31:0]), 64'h55);
        tick();
        // r2 cleared, r10 set in the same edge
        chk("set_clr_diff_count", 64'(busy_count), 64'd1);
        idle(); rd_addr = {4'd10, 4'd2};
        #1;
        chk("r2_written", 64'(rd_data[31:0]), 64'h55);
        chk("r2_r10_busy", 64'(rd_busy), 64'b10);

        // WAW and simultaneous set/clear on r7
        issue_valid = 1'b1; issue_dst = 4'd7;
        tick();
        chk("issue7_count", 64'(busy_count), 64'd2);
        #1;
        chk("waw_stall", 64'(stall), 64'd1);
        wr = 1'b1; wr_dst = 4'd7; wr_data = 32'h77;
        #1;
        chk("waw_resolved_stall", 64'(stall), 64'd0);
        tick();
        chk("set_wins_count", 64'(busy_count), 64'd2);
        idle(); rd_addr[7:4] = 4'd7;
        #1;
        chk("set_wins_busy7", 64'(rd_busy[1]), 64'd1);
        chk("r7_data", 64'(rd_data[63:32]), 64'h77);

        // Flush
        flush = 1'b1;
        tick();
        chk("flush_count0", 64'(busy_count), 64'd0);
        idle(); issue_valid = 1'b1;
        issue_dst = 4'd1; tick();
        issue_dst = 4'd4; tick();
        issue_dst = 4'd9; tick();
        chk("three_busy", 64'(busy_count), 64'd3);
        issue_dst = 4'd6; rd_en = 2'b01; rd_addr = {4'd4, 4'd1};
        flush = 1'b1; wr = 1'b1; wr_dst = 4'd8; wr_data = 32'hAA;
        #1;
        chk("flush_stall", 64'(stall), 64'd0);
        tick();
        chk("flush_count", 64'(busy_count), 64'd0);
        idle(); rd_addr = {4'd8, 4'd6};
        #1;
        chk("flush_r6_busy", 64'(rd_busy), 64'd0);
        chk("flush_wr_r8", 64'(rd_data[63:32]), 64'hAA);

        // Async reset mid-cycle
        issue_valid = 1'b1; issue_dst = 4'd3;
        tick();
        idle();
        chk("pre_async_count", 64'(busy_count), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_count", 64'(busy_count), 64'd0);
        rd_addr[3:0] = 4'd3;
        #1;
        chk("async_regs", 64'(rd_data[31:0]), 64'd0);
        #2 rst_n = 1'b1;

        // Register 0 behaviour
        tick();
        wr = 1'b1; wr_dst = 4'd0; wr_data = 32'hFFFF_FFFF; rd_addr[3:0] = 4'd0;
        #1;
        chk("r0_bypass", 64'(rd_data[31:0]), 64'(R0_EXP));
        tick();
        idle();
        #1;
        chk("r0_read", 64'(rd_data[31:0]), 64'(R0_EXP));
        issue_valid = 1'b1; issue_dst = 4'd0;
        tick();
        idle();
        chk("r0_issue_count", 64'(busy_count), 64'(R0_CNT));

        // Fill the scoreboard to its upper bound
        rst_n = 1'b0; #2 rst_n = 1'b1;
        wr = 1'b1; wr_dst = 4'd5; wr_data = 32'h1;
        tick();
        chk("wr_nonbusy_count", 64'(busy_count), 64'd0);
        idle();
        for (int r = 0; r < 16; r++) begin
            issue_valid = 1'b1; issue_dst = 4'(r);
            tick();
        end
        idle();
        chk("full_count", 64'(busy_count), 64'(FULL_CNT));
        issue_valid = 1'b1; issue_dst = 4'd3;
        #1;
        chk("full_waw_stall", 64'(stall), 64'd1);
        tick();
        chk("full_count_hold", 64'(busy_count), 64'(FULL_CNT));
        idle(); wr = 1'b1; wr_dst = 4'd15;
        tick();
        idle();
        chk("full_dec", 64'(busy_count), 64'(FULL_CNT - 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised decode-stage register file with a per-register busy scoreboard.
- Provides NUM_RD combinational read ports with write-through bypass from writeback.
- Tracks in-flight destination registers and raises a stall when an issuing instruction has a RAW or WAW hazard.
- Sits between the IF/ID buffer and the ID/EX register; writeback drives the write port.

Parameters:
DATA_W, 32, register data width
NUM_REGS, 16, number of architectural registers (power of two, >=2)
NUM_RD, 2, number of read ports (>=1)
ADDR_W (localparam), $clog2(NUM_REGS), register address width

Ports:
clk  input  1  system clock
rst_n  input  1  reset
rd_en  input  NUM_RD  per-port operand-used flag, for hazard check only
rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i is bits [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data
rd_busy  output  NUM_RD  port i source is still pending
issue_valid  input  1  decode issuing an instruction that writes issue_dst
issue_dst  input  ADDR_W  destination of the issuing instruction
stall  output  1  issue blocked this cycle
wr  input  1  writeback write enable
wr_dst  input  ADDR_W  writeback destination
wr_data  input  DATA_W  writeback data
flush  input  1  clear all busy bits (branch/interrupt redirect)
busy_count  output  ADDR_W+1  registered count of set busy bits

Behaviour:
Clock and reset:
- One clock, clk; reset rst_n is asynchronous and active-low.
- Reset: all registers = 0, all busy bits = 0, busy_count = 0.
- Outputs after reset: rd_data = 0 for every port, rd_busy = 0, stall = 0.
- Reset asserted mid-operation discards all pending state immediately, without waiting for a clock edge.

Write port:
- On posedge clk with wr=1, regs[wr_dst] <= wr_data.

Read ports (combinational, zero latency):
- rd_data[i] = wr_data if (wr && wr_dst==rd_addr[i]); otherwise regs[rd_addr[i]].
- Multiple ports may read the same address.

Pending status:
- rd_busy[i] = busy[rd_addr[i]] && !(wr && wr_dst==rd_addr[i]), so a same-cycle writeback counts as resolved.
- rd_busy is independent of rd_en.

Stall (combinational):
- stall = issue_valid && (RAW || WAW).
- RAW = OR over i of (rd_en[i] && rd_busy[i]).
- WAW = busy[issue_dst] && !(wr && wr_dst==issue_dst).
- stall is forced to 0 when flush=1.

Busy-bit update on posedge clk, priority high to low:
1. flush=1: all busy bits <= 0; issue and writeback clears are ignored. The register write still occurs.
2. Otherwise, a writeback with wr=1 clears busy[wr_dst].
3. Otherwise, an issue with issue_valid && !stall sets busy[issue_dst]. The set wins over a same-cycle clear of the same register, because a new producer is in flight.
- A stalled issue changes no state.

busy_count:
- Registered; equals the popcount of the busy vector after the edge.
- Maintained incrementally: +1 on a set of a clear bit, −1 on a clear of a set bit, 0 when a set and a clear hit the same register, 0 after flush.
- Range 0..NUM_REGS with no wrap.

Other rules:
- A writeback to a non-busy register is legal: data is written, busy is unaffected.
- Address compares are exact ADDR_W-bit equality; no out-of-range addresses exist.

Optional Feature:
Macro: ZERO_REG_EN
- Defined: register 0 is hardwired.
  - Reads of address 0 return 0, including bypass.
  - Writes to register 0 are dropped.
  - busy[0] is never set, so an issue to dst 0 never causes WAW and never increments busy_count.
  - rd_busy for address 0 is always 0.
- Undefined: register 0 behaves like any other register.

Test Plan:
- Reset and readback: rst_n=0 then 1; wr to r3 with 32'hDEADBEEF; next cycle rd_addr0=3 -> rd_data0=32'hDEADBEEF, rd_busy=0, busy_count=0.
- Bypass: wr=1, wr_dst=5, wr_data=32'h12345678 while rd_addr1=5 in the same cycle -> rd_data1=32'h12345678 combinationally, before the edge.
- RAW stall: issue dst=2 (busy_count->1); next cycle issue_valid with rd_en0=1, rd_addr0=2 -> stall=1, busy_count stays 1; then wr to r2 with 32'h55 -> stall=0 that cycle, rd_data0=32'h55.
- WAW and simultaneous set/clear: busy[7]=1; issue dst=7 with no wr -> stall=1; then wr_dst=7 with issue dst=7 in the same cycle -> stall=0, busy[7] stays 1, busy_count unchanged.
- Flush: set busy on r1, r4, r9 (busy_count=3); flush=1 together with issue dst=6 -> stall=0, busy_count=0, r6 not busy; async reset asserted mid-sequence clears busy_count without a clock edge.
- ZERO_REG_EN: wr r0 with 32'hFFFFFFFF, then read r0 -> 0; issue dst=0 -> busy_count stays 0. With the macro undefined -> read returns 32'hFFFFFFFF, busy_count=1.
